// File: rtl/lsu_dccm_arb_if.sv
// DCCM arbiter bus bundle: requester handshakes, DMA return path and the
// single DCCM bank port. The slave modport is the arbiter's view; the master
// modport is the requesters/DCCM side.
interface lsu_dccm_arb_if #(
    parameter int DCCM_BITS = 16,
    parameter int DATA_W    = 39,
    parameter int TAG_W     = 3
);
    logic                 lsu_freeze_dc3;

    logic                 ld_req;
    logic [DCCM_BITS-1:0] ld_addr_lo;
    logic [DCCM_BITS-1:0] ld_addr_hi;
    logic                 ld_gnt;

    logic                 sb_req;
    logic [DCCM_BITS-1:0] sb_addr;
    logic [DATA_W-1:0]    sb_data;
    logic                 sb_gnt;

    logic                 dma_req;
    logic                 dma_write;
    logic [DCCM_BITS-1:0] dma_addr;
    logic [DATA_W-1:0]    dma_wdata;
    logic [TAG_W-1:0]     dma_tag;
    logic                 dma_gnt;
    logic                 dma_rvalid;
    logic [TAG_W-1:0]     dma_rtag;
    logic [DATA_W-1:0]    dma_rdata;

    logic                 dccm_wren;
    logic                 dccm_rden;
    logic [DCCM_BITS-1:0] dccm_wr_addr;
    logic [DCCM_BITS-1:0] dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0] dccm_rd_addr_hi;
    logic [DATA_W-1:0]    dccm_wr_data;
    logic [DATA_W-1:0]    dccm_rd_data_lo;

    modport slave (
        input  lsu_freeze_dc3,
        input  ld_req, ld_addr_lo, ld_addr_hi,
        output ld_gnt,
        input  sb_req, sb_addr, sb_data,
        output sb_gnt,
        input  dma_req, dma_write, dma_addr, dma_wdata, dma_tag,
        output dma_gnt, dma_rvalid, dma_rtag, dma_rdata,
        output dccm_wren, dccm_rden, dccm_wr_addr,
        output dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
        input  dccm_rd_data_lo
    );

    modport master (
        output lsu_freeze_dc3,
        output ld_req, ld_addr_lo, ld_addr_hi,
        input  ld_gnt,
        output sb_req, sb_addr, sb_data,
        input  sb_gnt,
        output dma_req, dma_write, dma_addr, dma_wdata, dma_tag,
        input  dma_gnt, dma_rvalid, dma_rtag, dma_rdata,
        input  dccm_wren, dccm_rden, dccm_wr_addr,
        input  dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data,
        output dccm_rd_data_lo
    );
endinterface

// File: rtl/lsu_dccm_arb.sv
// Single-port DCCM access arbiter. One of load pipe, store-buffer drain or
// DMA wins the bank port each cycle; grants and DCCM controls are
// combinational. A DMA that keeps losing for STARVE_MAX cycles is promoted
// above everything. DMA reads return tag + data one cycle after grant.
//
// Optional build macro RV_DCCM_ARB_RR_EN: store-buffer and DMA alternate
// round-robin on contention (load still wins when DMA is not starved).
module lsu_dccm_arb #(
    parameter int DCCM_BITS  = 16,
    parameter int DATA_W     = 39,
    parameter int TAG_W      = 3,
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = 3
) (
    input logic           clk,
    input logic           rst_l,
    lsu_dccm_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_SB   = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    owner_e               owner;
    owner_e               sb_dma_pick;
    logic                 starved;
    logic [CNT_W-1:0]     starve_cnt;

    logic                 ld_gnt;
    logic                 sb_gnt;
    logic                 dma_gnt;
    logic                 dccm_wren;
    logic                 dccm_rden;
    logic [DCCM_BITS-1:0] dccm_wr_addr;
    logic [DCCM_BITS-1:0] dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0] dccm_rd_addr_hi;
    logic [DATA_W-1:0]    dccm_wr_data;

    // DMA read return stage: valid and tag one cycle behind the grant
    logic                 vld_p1;
    logic [TAG_W-1:0]     dma_rtag_p1;

    assign starved = (starve_cnt == STARVE_LIM);

`ifdef RV_DCCM_ARB_RR_EN
    // Set after a store grant so DMA wins the next sb/dma contention.
    logic rr_dma_turn;

    // Track the last store/DMA winner for round-robin alternation
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_dma_turn <= 1'b0;
        end else if (sb_gnt) begin
            rr_dma_turn <= 1'b1;
        end else if (dma_gnt) begin
            rr_dma_turn <= 1'b0;
        end
    end

    assign sb_dma_pick = rr_dma_turn ? OWN_DMA : OWN_SB;
`else
    assign sb_dma_pick = OWN_SB;
`endif

    // Pick the single owner of the bank port for this cycle
    always_comb begin
        owner = OWN_NONE;
        if (!bus.lsu_freeze_dc3) begin
            if (starved && bus.dma_req) begin
                owner = OWN_DMA;
            end else if (bus.ld_req) begin
                owner = OWN_LD;
            end else if (bus.sb_req && bus.dma_req) begin
                owner = sb_dma_pick;
            end else if (bus.sb_req) begin
                owner = OWN_SB;
            end else if (bus.dma_req) begin
                owner = OWN_DMA;
            end
        end
    end

    // Drive grants and the DCCM port from the selected owner; idle is all-zero
    always_comb begin
        ld_gnt          = 1'b0;
        sb_gnt          = 1'b0;
        dma_gnt         = 1'b0;
        dccm_wren       = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wr_addr    = '0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wr_data    = '0;
        unique case (owner)
            OWN_LD: begin
                ld_gnt          = 1'b1;
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = bus.ld_addr_lo;
                dccm_rd_addr_hi = bus.ld_addr_hi;
            end
            OWN_SB: begin
                sb_gnt       = 1'b1;
                dccm_wren    = 1'b1;
                dccm_wr_addr = bus.sb_addr;
                dccm_wr_data = bus.sb_data;
            end
            OWN_DMA: begin
                dma_gnt = 1'b1;
                if (bus.dma_write) begin
                    dccm_wren    = 1'b1;
                    dccm_wr_addr = bus.dma_addr;
                    dccm_wr_data = bus.dma_wdata;
                end else begin
                    dccm_rden       = 1'b1;
                    dccm_rd_addr_lo = bus.dma_addr;
                    dccm_rd_addr_hi = bus.dma_addr;
                end
            end
            default: begin
            end
        endcase
    end

    // Count consecutive cycles a DMA request loses; freeze holds the count
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            starve_cnt <= '0;
        end else if (!bus.lsu_freeze_dc3) begin
            if (!bus.dma_req || dma_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Register a granted DMA read so its tag returns with the bank data
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_p1      <= 1'b0;
            dma_rtag_p1 <= '0;
        end else begin
            vld_p1 <= dma_gnt && !bus.dma_write;
            if (dma_gnt && !bus.dma_write) begin
                dma_rtag_p1 <= bus.dma_tag;
            end
        end
    end

    assign bus.ld_gnt          = ld_gnt;
    assign bus.sb_gnt          = sb_gnt;
    assign bus.dma_gnt         = dma_gnt;
    assign bus.dccm_wren       = dccm_wren;
    assign bus.dccm_rden       = dccm_rden;
    assign bus.dccm_wr_addr    = dccm_wr_addr;
    assign bus.dccm_rd_addr_lo = dccm_rd_addr_lo;
    assign bus.dccm_rd_addr_hi = dccm_rd_addr_hi;
    assign bus.dccm_wr_data    = dccm_wr_data;
    assign bus.dma_rvalid      = vld_p1;
    assign bus.dma_rtag        = dma_rtag_p1;
    assign bus.dma_rdata       = bus.dccm_rd_data_lo;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb. Honors RV_DCCM_ARB_RR_EN for the
// store/DMA contention expectations.
module tb_lsu_dccm_arb;

    localparam int DCCM_BITS  = 16;
    localparam int DATA_W     = 39;
    localparam int TAG_W      = 3;
    localparam int STARVE_MAX = 7;
    localparam int CNT_W      = 3;

    logic clk;
    logic rst_l;
    int   n_cmp;
    int   n_mis;

    lsu_dccm_arb_if #(.DCCM_BITS(DCCM_BITS), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    lsu_dccm_arb #(
        .DCCM_BITS (DCCM_BITS),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) u_dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_reqs();
        bus.lsu_freeze_dc3 = 1'b0;
        bus.ld_req         = 1'b0;
        bus.sb_req         = 1'b0;
        bus.dma_req        = 1'b0;
        bus.dma_write      = 1'b0;
    endtask

    task automatic chk_gnts(input string tag, input logic [2:0] exp);
        chk(tag, {bus.ld_gnt, bus.sb_gnt, bus.dma_gnt}, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_l = 1'b0;
        idle_reqs();
        bus.ld_addr_lo      = '0;
        bus.ld_addr_hi      = '0;
        bus.sb_addr         = '0;
        bus.sb_data         = '0;
        bus.dma_addr        = '0;
        bus.dma_wdata       = '0;
        bus.dma_tag         = '0;
        bus.dccm_rd_data_lo = '0;

        // reset state
        #12;
        chk("rst_rvalid", bus.dma_rvalid, 0);
        chk("rst_rtag", bus.dma_rtag, 0);
        chk_gnts("rst_gnt", 3'b000);
        chk("rst_en", {bus.dccm_wren, bus.dccm_rden}, 0);
        chk("rst_cnt", u_dut.starve_cnt, 0);
        @(negedge clk);
        rst_l = 1'b1;

        // single load
        cyc();
        bus.ld_req = 1'b1; bus.ld_addr_lo = 16'h0004; bus.ld_addr_hi = 16'h0008;
        settle();
        chk_gnts("ld_gnt", 3'b100);
        chk("ld_en", {bus.dccm_wren, bus.dccm_rden}, 2'b01);
        chk("ld_addr_lo", bus.dccm_rd_addr_lo, 16'h0004);
        chk("ld_addr_hi", bus.dccm_rd_addr_hi, 16'h0008);
        cyc();
        idle_reqs();
        settle();
        chk_gnts("idle_gnt", 3'b000);
        chk("idle_port", {bus.dccm_wren, bus.dccm_rden, bus.dccm_rd_addr_lo,
                          bus.dccm_rd_addr_hi, bus.dccm_wr_addr}, 0);

        // three-way priority: ld, then sb, then dma
        cyc();
        bus.ld_req = 1'b1;
        bus.sb_req = 1'b1; bus.sb_addr = 16'h0020; bus.sb_data = 39'h55;
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0040; bus.dma_tag = 3'd2;
        settle();
        chk_gnts("pri_c0", 3'b100);
        cyc();
        bus.ld_req = 1'b0;
        settle();
        chk_gnts("pri_c1", 3'b010);
        chk("pri_c1_en", {bus.dccm_wren, bus.dccm_rden}, 2'b10);
        chk("pri_c1_waddr", bus.dccm_wr_addr, 16'h0020);
        chk("pri_c1_wdata", bus.dccm_wr_data, 39'h55);
        chk("pri_c1_cnt", u_dut.starve_cnt, 1);
        cyc();
        bus.sb_req = 1'b0;
        settle();
        chk_gnts("pri_c2", 3'b001);
        chk("pri_c2_en", {bus.dccm_wren, bus.dccm_rden}, 2'b01);
        chk("pri_c2_raddr", {bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, {16'h0040, 16'h0040});
        cyc();
        idle_reqs();
        settle();
        chk("pri_ret_vld", bus.dma_rvalid, 1);
        chk("pri_ret_tag", bus.dma_rtag, 2);
        chk("pri_cnt_clr", u_dut.starve_cnt, 0);

        // starvation promotion against a continuous load
        cyc();
        bus.ld_req = 1'b1; bus.ld_addr_lo = 16'h0010; bus.ld_addr_hi = 16'h0014;
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0080; bus.dma_tag = 3'd1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("stv_ld_%0d", i), bus.ld_gnt, (i < 7));
            chk($sformatf("stv_dma_%0d", i), bus.dma_gnt, (i == 7));
            chk($sformatf("stv_cnt_%0d", i), u_dut.starve_cnt, i);
            cyc();
            if (i == 7) bus.dma_req = 1'b0;
        end
        settle();
        chk_gnts("stv_after", 3'b100);
        chk("stv_cnt_clr", u_dut.starve_cnt, 0);
        chk("stv_ret_vld", bus.dma_rvalid, 1);
        chk("stv_ret_tag", bus.dma_rtag, 1);
        cyc();
        idle_reqs();
        settle();
        chk("stv_ret_pulse", bus.dma_rvalid, 0);

        // DMA read return with data passthrough
        cyc();
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0100; bus.dma_tag = 3'd5;
        settle();
        chk_gnts("rd_gnt", 3'b001);
        chk("rd_raddr", {bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}, {16'h0100, 16'h0100});
        cyc();
        idle_reqs();
        bus.dccm_rd_data_lo = 39'h12345678A;
        settle();
        chk("rd_vld", bus.dma_rvalid, 1);
        chk("rd_tag", bus.dma_rtag, 5);
        chk("rd_data", bus.dma_rdata, 39'h12345678A);
        cyc();
        settle();
        chk("rd_pulse", bus.dma_rvalid, 0);

        // freeze blocks grants and holds the starvation count
        cyc();
        bus.ld_req = 1'b1;
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0200; bus.dma_tag = 3'd3;
        cyc();
        cyc();
        bus.sb_req = 1'b1;
        bus.lsu_freeze_dc3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("frz_gnt_%0d", i), {bus.ld_gnt, bus.sb_gnt, bus.dma_gnt}, 0);
            chk($sformatf("frz_en_%0d", i), {bus.dccm_wren, bus.dccm_rden}, 0);
            chk($sformatf("frz_cnt_%0d", i), u_dut.starve_cnt, 2);
            cyc();
        end
        bus.lsu_freeze_dc3 = 1'b0;
        settle();
        chk_gnts("frz_release", 3'b100);
        chk("frz_rel_cnt", u_dut.starve_cnt, 2);
        cyc();
        idle_reqs();
        cyc();

        // back-to-back DMA reads return in order
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0010; bus.dma_tag = 3'd6;
        settle();
        chk_gnts("b2b_g0", 3'b001);
        cyc();
        bus.dma_addr = 16'h0014; bus.dma_tag = 3'd7;
        settle();
        chk_gnts("b2b_g1", 3'b001);
        chk("b2b_r0", {bus.dma_rvalid, bus.dma_rtag}, {1'b1, 3'd6});
        cyc();
        idle_reqs();
        settle();
        chk("b2b_r1", {bus.dma_rvalid, bus.dma_rtag}, {1'b1, 3'd7});
        cyc();
        settle();
        chk("b2b_end", bus.dma_rvalid, 0);

        // DMA write
        cyc();
        bus.dma_req = 1'b1; bus.dma_write = 1'b1; bus.dma_addr = 16'h0030; bus.dma_wdata = 39'h7F;
        settle();
        chk_gnts("dw_gnt", 3'b001);
        chk("dw_en", {bus.dccm_wren, bus.dccm_rden}, 2'b10);
        chk("dw_waddr", bus.dccm_wr_addr, 16'h0030);
        chk("dw_wdata", bus.dccm_wr_data, 39'h7F);
        cyc();
        idle_reqs();
        settle();
        chk("dw_no_ret", bus.dma_rvalid, 0);

        // store vs DMA write contention
        cyc();
        bus.sb_req = 1'b1; bus.sb_addr = 16'h0060; bus.sb_data = 39'h11;
        bus.dma_req = 1'b1; bus.dma_write = 1'b1; bus.dma_addr = 16'h0070; bus.dma_wdata = 39'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
`ifdef RV_DCCM_ARB_RR_EN
            chk($sformatf("con_gnt_%0d", i), {bus.sb_gnt, bus.dma_gnt},
                (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("con_wdata_%0d", i), bus.dccm_wr_data,
                (i % 2 == 0) ? 39'h11 : 39'h22);
`else
            chk($sformatf("con_gnt_%0d", i), {bus.sb_gnt, bus.dma_gnt}, 2'b10);
            chk($sformatf("con_wdata_%0d", i), bus.dccm_wr_data, 39'h11);
`endif
            cyc();
        end
        idle_reqs();
        cyc();

        // async reset clears a live return immediately
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0050; bus.dma_tag = 3'd4;
        settle();
        chk_gnts("ar_gnt", 3'b001);
        cyc();
        idle_reqs();
        settle();
        chk("ar_vld_pre", {bus.dma_rvalid, bus.dma_rtag}, {1'b1, 3'd4});
        rst_l = 1'b0;
        #1;
        chk("ar_vld_clr", {bus.dma_rvalid, bus.dma_rtag}, 0);
        #1;
        rst_l = 1'b1;

        // reset between grant and return drops the pending return
        cyc();
        bus.dma_req = 1'b1; bus.dma_write = 1'b0; bus.dma_addr = 16'h0058; bus.dma_tag = 3'd6;
        settle();
        chk_gnts("rm_gnt", 3'b001);
        rst_l = 1'b0;
        idle_reqs();
        cyc();
        settle();
        rst_l = 1'b1;
        cyc();
        settle();
        chk("rm_drop", bus.dma_rvalid, 0);
        chk("rm_idle", {bus.dccm_wren, bus.dccm_rden, bus.dccm_wr_data}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_dccm_arb.md
Name: lsu_dccm_arb

Overview:
- Single-port access arbiter and sequencer in front of the DCCM bank array.
- Three requesters share the port: LSU load pipe (DC1 read, possibly misaligned lo/hi), store-buffer drain (write), and DMA slave (aligned read or write).
- Exactly one access is granted per cycle. DMA read data is returned with its tag one cycle after grant.
- No grants are issued while the pipe is frozen.

Parameters:
- DCCM_BITS, 16, byte-address width of DCCM.
- DATA_W, 39, data width incl. ECC (32+7).
- TAG_W, 3, DMA request tag width.
- STARVE_MAX, 7, consecutive denied DMA cycles before DMA is promoted to top priority (1..2^CNT_W-1).
- CNT_W, 3, starvation counter width.

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset, asynchronous, active-low
- lsu_freeze_dc3  in  1  pipe freeze; blocks all grants
- ld_req  in  1  load read request
- ld_addr_lo  in  DCCM_BITS  load address, lo bank
- ld_addr_hi  in  DCCM_BITS  load address, hi bank
- ld_gnt  out  1  load granted this cycle
- sb_req  in  1  store-buffer write request
- sb_addr  in  DCCM_BITS  write address
- sb_data  in  DATA_W  write data
- sb_gnt  out  1  store granted this cycle
- dma_req  in  1  DMA request
- dma_write  in  1  1=write, 0=read
- dma_addr  in  DCCM_BITS  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_tag  in  TAG_W  DMA request tag
- dma_gnt  out  1  DMA granted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rtag  out  TAG_W  tag of returned read
- dma_rdata  out  DATA_W  DMA read data
- dccm_wren  out  1  to DCCM, write enable
- dccm_rden  out  1  to DCCM, read enable
- dccm_wr_addr  out  DCCM_BITS  to DCCM
- dccm_rd_addr_lo  out  DCCM_BITS  to DCCM
- dccm_rd_addr_hi  out  DCCM_BITS  to DCCM
- dccm_wr_data  out  DATA_W  to DCCM
- dccm_rd_data_lo  in  DATA_W  from DCCM, one cycle after rden

Behaviour:
- Grants and dccm_* outputs are combinational from the current requests and state. Each request is sampled, granted and driven to DCCM in the same cycle. A requester holds req and payload stable until it sees gnt.
- Mutual exclusion: at most one of ld_gnt/sb_gnt/dma_gnt per cycle. dccm_wren and dccm_rden are never both high.
- lsu_freeze_dc3=1: all gnt=0, dccm_wren=dccm_rden=0, starvation counter holds.
- Priority when starve_cnt<STARVE_MAX: ld > sb > dma.
- Priority when starve_cnt==STARVE_MAX: dma > ld > sb.
- starve_cnt (CNT_W flop):
  - +1 when dma_req & ~dma_gnt & ~freeze, saturating at STARVE_MAX.
  - Cleared on dma_gnt or when dma_req=0.
- Load grant: dccm_rden=1, rd_addr_lo/hi = ld_addr_lo/hi.
- Store grant: dccm_wren=1, wr_addr=sb_addr, wr_data=sb_data.
- DMA write grant: dccm_wren=1, wr_addr=dma_addr, wr_data=dma_wdata.
- DMA read grant: dccm_rden=1, rd_addr_lo=rd_addr_hi=dma_addr.
- Idle: all dccm_* outputs driven 0.
- DMA read return: read granted in cycle N gives dma_rvalid=1 in N+1, dma_rtag = tag registered at N, dma_rdata = dccm_rd_data_lo (passthrough). dma_rvalid is a single-cycle pulse and is unaffected by freeze in N+1.
- Back-to-back DMA reads: one return per cycle, in grant order.
- Reset (async assert): starve_cnt=0, dma_rvalid=0, dma_rtag=0, RR state=0. Combinational outputs are 0 whenever all req=0.
- Reset mid-operation: a pending read return (granted at N, reset before N+1) is dropped; no dma_rvalid after reset deasserts.

Optional Feature:
- Macro: RV_DCCM_ARB_RR_EN.
- Defined: when not starved, ld keeps top priority. sb vs dma alternates round-robin via a 1-bit last-winner flop: after an sb grant, dma wins the next contention and vice versa. Flop resets to 0 (sb favoured first). Starvation promotion still applies.
- Undefined: fixed ld > sb > dma as above; no last-winner flop.

Test Plan:
- Reset, then ld_req with ld_addr_lo=0x0004, ld_addr_hi=0x0008 -> same cycle ld_gnt=1, dccm_rden=1, rd_addr_lo=0x0004, rd_addr_hi=0x0008; sb_gnt=dma_gnt=0.
- ld_req+sb_req+dma_req (read) all held; ld drops after 1 cycle -> cycle0 ld_gnt, cycle1 sb_gnt, then dma_gnt once sb_req drops.
- dma_req read held with ld_req held continuously, STARVE_MAX=7 -> dma_gnt in cycle 7 exactly; counter then 0; next cycle ld_gnt.
- DMA read tag=5 at addr 0x0100, memory returns 0x12345678A -> next cycle dma_rvalid=1, dma_rtag=5, dma_rdata=0x12345678A, single pulse.
- lsu_freeze_dc3=1 for 3 cycles with all reqs high -> no gnt, wren=rden=0, starve_cnt unchanged; freeze drop -> ld_gnt.
- RV_DCCM_ARB_RR_EN: sb_req and dma_req (write) both held, no ld -> grants alternate sb, dma, sb, dma.
